multicycle_controller: RTL and testbench

- Next-generation main control unit for the RISC-V datapath. Replaces the single-step opcode decoder with a multi-cycle FSM: FETCH, DECODE, EXECUTE, MEM, WRITEBACK.
- Adds an I-type ALU opcode and JAL, plus ready handshakes to instruction and data memory, a memory-wait watchdog, illegal-opcode trapping and a retired-instruction counter.
- Sits between the instruction register/memories and the datapath muxes, ALU controller and register file.

---
 rtl/controller_pkg.sv | 34 +++
 rtl/main_decoder.sv | 28 ++
 rtl/multicycle_controller.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/controller_pkg.sv
// Shared encodings for the multi-cycle main control unit: opcodes, ALU and
// writeback selects, trap causes, FSM states and instruction classes.
package controller_pkg;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_SD  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [1:0] ALU_ADD    = 2'b00;
   localparam logic [1:0] ALU_SUB    = 2'b01;
   localparam logic [1:0] ALU_RFUNCT = 2'b10;
   localparam logic [1:0] ALU_IFUNCT = 2'b11;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_IMEM    = 2'b10;
   localparam logic [1:0] CAUSE_DMEM    = 2'b11;

   typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP} state_t;

   typedef enum logic [2:0] {CLS_R, CLS_I, CLS_LD, CLS_SD, CLS_BEQ, CLS_JAL} instr_class_t;

   function automatic logic is_mem_class(input instr_class_t c);
      return (c == CLS_LD) || (c == CLS_SD);
   endfunction

endpackage

// File: rtl/main_decoder.sv
// Maps a 7-bit opcode to its instruction class and a legality flag; optional
// classes are reported illegal when their enable parameter is cleared.
module main_decoder
   import controller_pkg::*;
#(
   parameter bit ENABLE_IALU = 1'b1,
   parameter bit ENABLE_JAL  = 1'b1
) (
   input  logic [6:0]   opcode,
   output instr_class_t cls,
   output logic         legal
);

   always_comb begin
      cls   = CLS_R;
      legal = 1'b1;
      case (opcode)
         OP_R:   cls = CLS_R;
         OP_I:   begin cls = CLS_I;   legal = ENABLE_IALU; end
         OP_LD:  cls = CLS_LD;
         OP_SD:  cls = CLS_SD;
         OP_BEQ: cls = CLS_BEQ;
         OP_JAL: begin cls = CLS_JAL; legal = ENABLE_JAL;  end
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle main control FSM (FETCH/DECODE/EXECUTE/MEM/WRITEBACK) with memory
// handshakes, a wait watchdog, sticky trapping and a retired-instruction counter.
module multicycle_controller
   import controller_pkg::*;
#(
   parameter int ALUOP_W     = 2,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32,
   parameter bit ENABLE_IALU = 1'b1,
   parameter bit ENABLE_JAL  = 1'b1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [6:0]         opcode,
   input  logic               zero,
   input  logic               imem_ready,
   input  logic               dmem_ready,
   output logic               pc_write,
   output logic               pc_src,
   output logic               ir_write,
   output logic               imem_read,
   output logic               alu_src,
   output logic [ALUOP_W-1:0] alu_op,
   output logic               mem_read,
   output logic               mem_write,
   output logic               reg_write,
   output logic [1:0]         wb_sel,
   output logic               branch,
   output logic               instr_done,
   output logic [CNT_W-1:0]   retired,
   output logic               trap,
   output logic [1:0]         trap_cause
);

   localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   state_t             state;
   logic [6:0]         opcode_q;
   logic [6:0]         dec_opcode;
   instr_class_t       cls;
   logic               dec_legal;
   logic [WAIT_W-1:0]  wait_cnt;
   logic [CNT_W-1:0]   retired_q;
   logic [1:0]         trap_cause_q;
   logic               waiting;
   logic               timeout;

   // The decoder sees the live opcode only while decoding; afterwards it
   // re-classifies the latched copy so outputs stay Moore-style.
   assign dec_opcode = (state == DECODE) ? opcode : opcode_q;

   main_decoder #(
      .ENABLE_IALU (ENABLE_IALU),
      .ENABLE_JAL  (ENABLE_JAL)
   ) u_main_decoder (
      .opcode (dec_opcode),
      .cls    (cls),
      .legal  (dec_legal)
   );

   assign waiting = ((state == FETCH) && !imem_ready) || ((state == MEM) && !dmem_ready);
   assign timeout = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_LAST);

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= FETCH;
         opcode_q     <= '0;
         wait_cnt     <= '0;
         retired_q    <= '0;
         trap_cause_q <= CAUSE_NONE;
      end else begin
         if (instr_done)
            retired_q <= retired_q + CNT_W'(1);
         wait_cnt <= waiting ? wait_cnt + WAIT_W'(1) : '0;
         case (state)
            FETCH: begin
               if (imem_ready)
                  state <= DECODE;
               else if (timeout) begin
                  state        <= TRAP;
                  trap_cause_q <= CAUSE_IMEM;
               end
            end
            DECODE: begin
               opcode_q <= opcode;
               if (dec_legal)
                  state <= EXECUTE;
               else begin
                  state        <= TRAP;
                  trap_cause_q <= CAUSE_ILLEGAL;
               end
            end
            EXECUTE: begin
               if (is_mem_class(cls))
                  state <= MEM;
               else if ((cls == CLS_BEQ) || (cls == CLS_JAL))
                  state <= FETCH;
               else
                  state <= WRITEBACK;
            end
            MEM: begin
               if (dmem_ready)
                  state <= (cls == CLS_LD) ? WRITEBACK : FETCH;
               else if (timeout) begin
                  state        <= TRAP;
                  trap_cause_q <= CAUSE_DMEM;
               end
            end
            WRITEBACK: state <= FETCH;
            TRAP:      state <= TRAP;
            default:   state <= FETCH;
         endcase
      end
   end

   // Everything is forced low while reset is high so an aborted instruction
   // cannot commit PC, register or memory state on the reset cycle.
   always_comb begin
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      ir_write   = 1'b0;
      imem_read  = 1'b0;
      alu_src    = 1'b0;
      alu_op     = '0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      wb_sel     = WB_ALU;
      branch     = 1'b0;
      instr_done = 1'b0;
      retired    = '0;
      trap       = 1'b0;
      trap_cause = CAUSE_NONE;
      if (!reset) begin
         retired    = retired_q;
         trap       = (state == TRAP);
         trap_cause = trap_cause_q;
         case (state)
            FETCH: begin
               imem_read = 1'b1;
               ir_write  = imem_ready;
               pc_write  = imem_ready;
            end
            EXECUTE: begin
               case (cls)
                  CLS_R: alu_op = ALUOP_W'(ALU_RFUNCT);
                  CLS_I: begin
                     alu_op  = ALUOP_W'(ALU_IFUNCT);
                     alu_src = 1'b1;
                  end
                  CLS_LD, CLS_SD: begin
                     alu_op  = ALUOP_W'(ALU_ADD);
                     alu_src = 1'b1;
                  end
                  CLS_BEQ: begin
                     alu_op     = ALUOP_W'(ALU_SUB);
                     branch     = 1'b1;
                     pc_src     = 1'b1;
                     pc_write   = zero;
                     instr_done = 1'b1;
                  end
                  CLS_JAL: begin
                     reg_write  = 1'b1;
                     wb_sel     = WB_PC4;
                     pc_src     = 1'b1;
                     pc_write   = 1'b1;
                     instr_done = 1'b1;
                  end
                  default: ;
               endcase
            end
            MEM: begin
               if (cls == CLS_LD)
                  mem_read = 1'b1;
               else begin
                  mem_write  = 1'b1;
                  instr_done = dmem_ready;
               end
            end
            WRITEBACK: begin
               reg_write  = 1'b1;
               wb_sel     = (cls == CLS_LD) ? WB_MEM : WB_ALU;
               instr_done = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: a default instance driven against a per-class
// cycle schedule model, plus a reduced instance for watchdog, wrap and disable cases.
module tb_multicycle_controller;

   typedef struct packed {
      logic       pc_write;
      logic       pc_src;
      logic       ir_write;
      logic       imem_read;
      logic       alu_src;
      logic [1:0] alu_op;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic [1:0] wb_sel;
      logic       branch;
      logic       instr_done;
      logic       trap;
      logic [1:0] trap_cause;
   } ctl_t;

   localparam int K_R = 0, K_I = 1, K_LD = 2, K_SD = 3, K_BEQ = 4, K_JAL = 5, K_ILL = 6;

   logic       clock = 1'b0;
   logic       reset;
   logic [6:0] opcode;
   logic       zero, imem_ready, dmem_ready;

   logic        pc_write, pc_src, ir_write, imem_read, alu_src, mem_read, mem_write;
   logic        reg_write, branch, instr_done, trap;
   logic [1:0]  alu_op, wb_sel, trap_cause;
   logic [31:0] retired;

   logic        s_pc_write, s_pc_src, s_ir_write, s_imem_read, s_alu_src, s_mem_read, s_mem_write;
   logic        s_reg_write, s_branch, s_instr_done, s_trap;
   logic [1:0]  s_alu_op, s_wb_sel, s_trap_cause;
   logic [3:0]  s_retired;

   ctl_t obs, s_obs;
   assign obs   = {pc_write, pc_src, ir_write, imem_read, alu_src, alu_op, mem_read, mem_write,
                   reg_write, wb_sel, branch, instr_done, trap, trap_cause};
   assign s_obs = {s_pc_write, s_pc_src, s_ir_write, s_imem_read, s_alu_src, s_alu_op, s_mem_read,
                   s_mem_write, s_reg_write, s_wb_sel, s_branch, s_instr_done, s_trap, s_trap_cause};

   logic [16:0] exp_q[$];
   logic [9:0]  stim_q[$];
   logic [31:0] ret_ref;
   int          vectors = 0;
   int          misc = 0;

   always #5 clock = ~clock;

   multicycle_controller dut (
      .clock(clock), .reset(reset), .opcode(opcode), .zero(zero),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .imem_read(imem_read),
      .alu_src(alu_src), .alu_op(alu_op), .mem_read(mem_read), .mem_write(mem_write),
      .reg_write(reg_write), .wb_sel(wb_sel), .branch(branch), .instr_done(instr_done),
      .retired(retired), .trap(trap), .trap_cause(trap_cause)
   );

   multicycle_controller #(
      .MEM_TIMEOUT(4), .CNT_W(4), .ENABLE_IALU(1'b0)
   ) dut_small (
      .clock(clock), .reset(reset), .opcode(opcode), .zero(zero),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .pc_write(s_pc_write), .pc_src(s_pc_src), .ir_write(s_ir_write), .imem_read(s_imem_read),
      .alu_src(s_alu_src), .alu_op(s_alu_op), .mem_read(s_mem_read), .mem_write(s_mem_write),
      .reg_write(s_reg_write), .wb_sel(s_wb_sel), .branch(s_branch), .instr_done(s_instr_done),
      .retired(s_retired), .trap(s_trap), .trap_cause(s_trap_cause)
   );

   function automatic logic [6:0] opcode_of(input int k);
      case (k)
         K_R:     return 7'b0110011;
         K_I:     return 7'b0010011;
         K_LD:    return 7'b0000011;
         K_SD:    return 7'b0100011;
         K_BEQ:   return 7'b1100011;
         K_JAL:   return 7'b1101111;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic void push(input ctl_t e, input logic [6:0] op, input logic z,
                                input logic im, input logic dm);
      exp_q.push_back(e);
      stim_q.push_back({op, z, im, dm});
   endfunction

   // Expected per-cycle controls of one instruction, with the inputs to apply.
   // Inputs a phase must ignore are randomized.
   task automatic plan_instr(input int k, input logic z, input int df, input int dm, input int trap_cycles);
      ctl_t e;
      for (int i = 0; i < df; i++) begin
         e = '0; e.imem_read = 1'b1;
         push(e, 7'($urandom), 1'($urandom), 1'b0, 1'($urandom));
      end
      e = '0; e.imem_read = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
      push(e, 7'($urandom), 1'($urandom), 1'b1, 1'($urandom));
      e = '0;
      push(e, opcode_of(k), 1'($urandom), 1'($urandom), 1'($urandom));
      if (k == K_ILL) begin
         e = '0; e.trap = 1'b1; e.trap_cause = 2'b01;
         for (int i = 0; i < trap_cycles; i++)
            push(e, 7'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         return;
      end
      e = '0;
      case (k)
         K_R:        e.alu_op = 2'b10;
         K_I:        begin e.alu_op = 2'b11; e.alu_src = 1'b1; end
         K_LD, K_SD: begin e.alu_op = 2'b00; e.alu_src = 1'b1; end
         K_BEQ:      begin e.alu_op = 2'b01; e.branch = 1'b1; e.pc_src = 1'b1;
                           e.pc_write = z; e.instr_done = 1'b1; end
         default:    begin e.reg_write = 1'b1; e.wb_sel = 2'b10; e.pc_src = 1'b1;
                           e.pc_write = 1'b1; e.instr_done = 1'b1; end
      endcase
      push(e, 7'($urandom), z, 1'($urandom), 1'($urandom));
      if (k == K_LD || k == K_SD) begin
         e = '0; e.mem_read = (k == K_LD); e.mem_write = (k == K_SD);
         for (int i = 0; i < dm; i++)
            push(e, 7'($urandom), 1'($urandom), 1'($urandom), 1'b0);
         e.instr_done = (k == K_SD);
         push(e, 7'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      end
      if (k == K_R || k == K_I || k == K_LD) begin
         e = '0; e.reg_write = 1'b1; e.wb_sel = (k == K_LD) ? 2'b01 : 2'b00; e.instr_done = 1'b1;
         push(e, 7'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      end
   endtask

   // Every task is entered just after a falling edge and leaves just after one.
   task automatic run_queue();
      ctl_t        e;
      logic [9:0]  s;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         s = stim_q.pop_front();
         {opcode, zero, imem_ready, dmem_ready} = s;
         #1;
         vectors++;
         if (obs !== e) begin
            misc++;
            $display("FAIL ctl: got %h expected %h (stim %h)", obs, e, s);
         end
         vectors++;
         if (retired !== ret_ref) begin
            misc++;
            $display("FAIL retired: got %0d expected %0d", retired, ret_ref);
         end
         if (e.instr_done) ret_ref = ret_ref + 1;
         @(negedge clock);
      end
   endtask

   task automatic step(input logic [6:0] op, input logic z, input logic im, input logic dm);
      {opcode, zero, imem_ready, dmem_ready} = {op, z, im, dm};
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(7'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      vectors++;
      if (obs !== '0 || retired !== '0) begin
         misc++;
         $display("FAIL reset_outputs: ctl=%h retired=%0d, need all 0", obs, retired);
      end
      vectors++;
      if (s_obs !== '0 || s_retired !== '0) begin
         misc++;
         $display("FAIL reset_outputs_small: ctl=%h retired=%0d, need all 0", s_obs, s_retired);
      end
      @(negedge clock);
      reset = 1'b0;
      ret_ref = '0;
      exp_q.delete();
      stim_q.delete();
   endtask

   task automatic test_reset();
      ctl_t e;
      do_reset();
      e = '0; e.imem_read = 1'b1;
      step(7'($urandom), 1'($urandom), 1'b0, 1'($urandom));
      vectors++;
      if (obs !== e || retired !== 32'd0) begin
         misc++;
         $display("FAIL post_reset_fetch: ctl=%h retired=%0d, need %h and 0", obs, retired, e);
      end
      @(negedge clock);
   endtask

   task automatic test_rtype();
      do_reset();
      plan_instr(K_R, 1'($urandom), 0, 0, 0);
      run_queue();
   endtask

   task automatic test_load_wait();
      do_reset();
      plan_instr(K_LD, 1'($urandom), 0, 3, 0);
      plan_instr(K_SD, 1'($urandom), 1, 2, 0);
      run_queue();
   endtask

   task automatic test_beq();
      do_reset();
      plan_instr(K_BEQ, 1'b1, 0, 0, 0);
      plan_instr(K_BEQ, 1'b0, 0, 0, 0);
      run_queue();
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 40; n++)
         plan_instr($urandom_range(K_R, K_JAL), 1'($urandom), $urandom_range(0, 5), $urandom_range(0, 5), 0);
      run_queue();
   endtask

   task automatic test_illegal();
      ctl_t e;
      do_reset();
      plan_instr(K_ILL, 1'b0, 1, 0, 20);
      run_queue();
      do_reset();
      step(7'($urandom), 1'($urandom), 1'b0, 1'($urandom));
      vectors++;
      if (trap !== 1'b0 || trap_cause !== 2'b00 || imem_read !== 1'b1) begin
         misc++;
         $display("FAIL trap_cleared: trap=%b cause=%b imem_read=%b, need 0 00 1", trap, trap_cause, imem_read);
      end
      @(negedge clock);
      do_reset();
      step(7'($urandom), 1'($urandom), 1'b1, 1'($urandom));
      @(negedge clock);
      step(opcode_of(K_I), 1'($urandom), 1'($urandom), 1'($urandom));
      @(negedge clock);
      step(7'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      e = '0; e.trap = 1'b1; e.trap_cause = 2'b01;
      vectors++;
      if (s_obs !== e) begin
         misc++;
         $display("FAIL ialu_disabled_trap: got %h expected %h", s_obs, e);
      end
      e = '0; e.alu_op = 2'b11; e.alu_src = 1'b1;
      vectors++;
      if (obs !== e) begin
         misc++;
         $display("FAIL ialu_enabled_exec: got %h expected %h", obs, e);
      end
      @(negedge clock);
   endtask

   task automatic test_timeout();
      do_reset();
      for (int c = 1; c <= 4; c++) begin
         step(7'($urandom), 1'($urandom), 1'b0, 1'($urandom));
         vectors++;
         if (s_imem_read !== 1'b1 || s_trap !== 1'b0) begin
            misc++;
            $display("FAIL imem_wait_%0d: imem_read=%b trap=%b, need 1 0", c, s_imem_read, s_trap);
         end
         @(negedge clock);
      end
      step(7'($urandom), 1'($urandom), 1'b0, 1'($urandom));
      vectors++;
      if (s_trap !== 1'b1 || s_trap_cause !== 2'b10 || s_imem_read !== 1'b0) begin
         misc++;
         $display("FAIL imem_timeout: trap=%b cause=%b imem_read=%b, need 1 10 0", s_trap, s_trap_cause, s_imem_read);
      end
      vectors++;
      if (trap !== 1'b0 || imem_read !== 1'b1) begin
         misc++;
         $display("FAIL imem_no_timeout_default: trap=%b imem_read=%b, need 0 1", trap, imem_read);
      end
      @(negedge clock);

      do_reset();
      for (int c = 1; c <= 3; c++) begin
         step(7'($urandom), 1'($urandom), 1'b0, 1'($urandom));
         @(negedge clock);
      end
      step(7'($urandom), 1'($urandom), 1'b1, 1'($urandom));
      vectors++;
      if (s_ir_write !== 1'b1 || s_trap !== 1'b0) begin
         misc++;
         $display("FAIL late_ready_fetch: ir_write=%b trap=%b, need 1 0", s_ir_write, s_trap);
      end
      @(negedge clock);
      step(opcode_of(K_R), 1'($urandom), 1'($urandom), 1'($urandom));
      vectors++;
      if (s_obs !== '0) begin
         misc++;
         $display("FAIL late_ready_decode: got %h expected 0", s_obs);
      end
      @(negedge clock);

      do_reset();
      step(7'($urandom), 1'($urandom), 1'b1, 1'($urandom));
      @(negedge clock);
      step(opcode_of(K_LD), 1'($urandom), 1'($urandom), 1'($urandom));
      @(negedge clock);
      step(7'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      @(negedge clock);
      for (int c = 1; c <= 4; c++) begin
         step(7'($urandom), 1'($urandom), 1'($urandom), 1'b0);
         vectors++;
         if (s_mem_read !== 1'b1 || s_trap !== 1'b0) begin
            misc++;
            $display("FAIL dmem_wait_%0d: mem_read=%b trap=%b, need 1 0", c, s_mem_read, s_trap);
         end
         @(negedge clock);
      end
      step(7'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      vectors++;
      if (s_trap !== 1'b1 || s_trap_cause !== 2'b11 || s_mem_read !== 1'b0) begin
         misc++;
         $display("FAIL dmem_timeout: trap=%b cause=%b mem_read=%b, need 1 11 0", s_trap, s_trap_cause, s_mem_read);
      end
      @(negedge clock);
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int n = 0; n < 17; n++)
         plan_instr(K_JAL, 1'($urandom), 0, 0, 0);
      run_queue();
      vectors++;
      if (retired !== ret_ref) begin
         misc++;
         $display("FAIL jal_count: got %0d expected %0d", retired, ret_ref);
      end
      vectors++;
      if (s_retired !== ret_ref[3:0]) begin
         misc++;
         $display("FAIL jal_wrap_small: got %0d expected %0d", s_retired, ret_ref[3:0]);
      end
   endtask

   task automatic test_reset_abort();
      do_reset();
      plan_instr(K_JAL, 1'b0, 0, 0, 0);
      run_queue();
      step(7'($urandom), 1'($urandom), 1'b1, 1'($urandom));
      @(negedge clock);
      step(opcode_of(K_SD), 1'($urandom), 1'($urandom), 1'($urandom));
      @(negedge clock);
      step(7'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      @(negedge clock);
      step(7'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      vectors++;
      if (mem_write !== 1'b1 || retired !== 32'd1) begin
         misc++;
         $display("FAIL sd_mem_phase: mem_write=%b retired=%0d, need 1 1", mem_write, retired);
      end
      @(negedge clock);
      reset = 1'b1;
      step(7'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      vectors++;
      if (mem_write !== 1'b0 || pc_write !== 1'b0 || reg_write !== 1'b0 || instr_done !== 1'b0) begin
         misc++;
         $display("FAIL abort_cycle: mem_write=%b pc_write=%b reg_write=%b instr_done=%b, need 0",
                  mem_write, pc_write, reg_write, instr_done);
      end
      @(negedge clock);
      reset = 1'b0;
      step(7'($urandom), 1'($urandom), 1'b0, 1'($urandom));
      vectors++;
      if (retired !== 32'd0 || imem_read !== 1'b1) begin
         misc++;
         $display("FAIL after_abort: retired=%0d imem_read=%b, need 0 1", retired, imem_read);
      end
      @(negedge clock);
   endtask

   initial begin
      reset = 1'b1;
      {opcode, zero, imem_ready, dmem_ready} = '0;
      ret_ref = '0;
      test_reset();
      test_rtype();
      test_load_wait();
      test_beq();
      test_random();
      test_illegal();
      test_timeout();
      test_back_to_back();
      test_reset_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
      $finish;
   end

endmodule
